// File: rtl/jtsdram_bank_tester.sv
// Single-bank SDRAM test engine: writes a selectable pattern over a window of the bank,
// reads it back, compares, and keeps sticky/bad, error and clean-pass counters.
module jtsdram_bank_tester #(
   parameter int          AW       = 22,
   parameter int          DW       = 16,
   parameter int          SPAN     = 4096,
   parameter int unsigned BASE     = 0,
   parameter bit          WRITABLE = 1'b1,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          TIMEOUT  = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            loop,
   input  logic [1:0]      mode,
   output logic            busy,
   output logic            done,
   output logic            bad,
   output logic [15:0]     err_cnt,
   output logic [15:0]     pass_cnt,
   output logic [AW-1:0]   ba_addr,
   output logic            ba_rd,
   output logic            ba_wr,
   output logic [DW-1:0]   ba_din,
   output logic [DW/8-1:0] ba_din_m,
   input  logic            ba_ack,
   input  logic            ba_rdy,
   input  logic [DW-1:0]   data_read
);

   localparam int IW = (SPAN > 1) ? $clog2(SPAN) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int WB = (DW == 16) ? 4 : 3;
   localparam logic [IW-1:0] LAST_IDX = IW'(SPAN - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
   localparam logic [AW-1:0] BASE_A   = AW'(BASE);

   typedef enum logic [2:0] {
      S_IDLE, S_WREQ, S_WWAIT, S_RREQ, S_RWAIT, S_PEND
   } state_t;

   typedef enum logic [1:0] {
      PAT_ADDR, PAT_NADDR, PAT_LFSR, PAT_WALK
   } pat_t;

   localparam state_t FIRST_STATE = WRITABLE ? S_WREQ : S_RREQ;

   state_t        state, state_d;
   pat_t          mode_q;
   logic [IW-1:0] idx;
   logic [15:0]   lfsr;
   logic [TW-1:0] tmr;
   logic          pass_err;

   logic [AW-1:0] addr;
   logic [DW-1:0] pattern;
   logic [DW-1:0] walk;
   logic [15:0]   lfsr_next;
   logic          last;
   logic          timeout;
   logic          mismatch;
   logic          step;
   logic          err_ev;
   logic          restart;

   assign last      = (idx == LAST_IDX);
   assign timeout   = (tmr == TMR_LAST);
   assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign mismatch  = (data_read != pattern);

   // The test window wraps at the top of the bank because the sum is kept at AW bits.
   always_comb begin
      addr = BASE_A + AW'(idx);
      walk = '0;
      walk[addr[WB-1:0]] = 1'b1;
      unique case (mode_q)
         PAT_ADDR:  pattern = DW'(addr);
         PAT_NADDR: pattern = ~DW'(addr);
         PAT_LFSR:  pattern = lfsr[DW-1:0];
         default:   pattern = walk;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_d = state;
      step    = 1'b0;
      err_ev  = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_d = FIRST_STATE;
         S_WREQ: begin
            if (ba_ack && ba_rdy) step = 1'b1;
            else if (ba_ack)      state_d = S_WWAIT;
            else if (timeout)     {step, err_ev} = 2'b11;
         end
         S_WWAIT: begin
            if (ba_rdy)       step = 1'b1;
            else if (timeout) {step, err_ev} = 2'b11;
         end
         S_RREQ: begin
            if (ba_ack && ba_rdy) {step, err_ev} = {1'b1, mismatch};
            else if (ba_ack)      state_d = S_RWAIT;
            else if (timeout)     {step, err_ev} = 2'b11;
         end
         S_RWAIT: begin
            if (ba_rdy)       {step, err_ev} = {1'b1, mismatch};
            else if (timeout) {step, err_ev} = 2'b11;
         end
         S_PEND:  state_d = loop ? FIRST_STATE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A finished word (by rdy or by timeout) moves on to the next request or phase.
      if (step) begin
         if (state == S_WREQ || state == S_WWAIT) state_d = last ? S_RREQ : S_WREQ;
         else                                     state_d = last ? S_PEND : S_RREQ;
      end
   end

   assign restart = step || (state_d != state);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         mode_q   <= PAT_ADDR;
         idx      <= '0;
         lfsr     <= SEED;
         tmr      <= '0;
         bad      <= 1'b0;
         err_cnt  <= '0;
         pass_cnt <= '0;
         pass_err <= 1'b0;
      end else begin
         state <= state_d;
         if (state == S_IDLE || state == S_PEND || restart) tmr <= '0;
         else                                              tmr <= tmr + TW'(1);

         if (state == S_IDLE && start) begin
            mode_q   <= pat_t'(mode);
            idx      <= '0;
            lfsr     <= SEED;
            bad      <= 1'b0;
            err_cnt  <= '0;
            pass_cnt <= '0;
            pass_err <= 1'b0;
         end

         // The LFSR restarts from SEED whenever a phase begins, so both phases see one sequence.
         if (step) begin
            idx  <= last ? '0 : idx + IW'(1);
            lfsr <= last ? SEED : lfsr_next;
         end

         if (err_ev) begin
            bad      <= 1'b1;
            pass_err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
         end

         if (state == S_PEND) begin
            if (!pass_err && pass_cnt != '1) pass_cnt <= pass_cnt + 16'd1;
            pass_err <= 1'b0;
         end
      end
   end

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_PEND);
   assign ba_wr    = WRITABLE && (state == S_WREQ);
   assign ba_rd    = (state == S_RREQ);
   assign ba_addr  = busy ? addr : '0;
   assign ba_din   = ba_wr ? pattern : '0;
   assign ba_din_m = '0;

endmodule
